letter_show_writer: RTL and testbench

Write-side controller for the 64K x 1-bit letter-show bitmap RAM (256 x 256 pixels, ada = {y[7:0], x[7:0]}).
Accepts character-draw requests (ASCII code plus cell position) and whole-bitmap clear requests.
Fetches 8-pixel glyph rows from an external synchronous font ROM and serialises them into 1-bit writes on RAM port A.
The display pipeline reads port B independently; this block owns port A exclusively.

---
 rtl/letter_show_pkg.sv | 35 +++
 rtl/letter_show_writer_serializer.sv | 38 +++
 rtl/letter_show_writer.sv | 187 ++++++++++++++++++
 tb/tb_letter_show_writer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/letter_show_pkg.sv
// Shared state encoding, bitmap/glyph geometry and code sanitising for the
// letter-show bitmap writer.
package letter_show_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      FETCH,
      WAIT,
      WRITE,
      FIN
   } state_t;

   localparam int GLYPH_W   = 8;
   localparam int GLYPH_H   = 16;
   localparam int BMP_LOG2  = 8;
   localparam int CELL_COLS = 32;
   localparam int CELL_ROWS = 16;

   localparam logic [6:0] ASCII_MIN = 7'h20;
   localparam logic [6:0] ASCII_MAX = 7'h7E;

   localparam int COL_W  = $clog2(GLYPH_W);
   localparam int ROW_W  = $clog2(GLYPH_H);
   localparam int CX_W   = $clog2(CELL_COLS);
   localparam int CY_W   = $clog2(CELL_ROWS);
   localparam int ADDR_W = 2 * BMP_LOG2;

   // Anything outside the printable ASCII range is drawn as the blank glyph.
   function automatic logic [6:0] printable_code(input logic [6:0] code,
                                                 input logic [6:0] blank);
      return ((code < ASCII_MIN) || (code > ASCII_MAX)) ? blank : code;
   endfunction

endpackage

// File: rtl/letter_show_writer_serializer.sv
// Turns one 8-pixel glyph row into a stream of single pixels, leftmost first,
// and tracks which column of the cell is being emitted.
module letter_row_serializer
   import letter_show_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic               shift,
   input  logic [GLYPH_W-1:0] data_in,
   output logic               next_bit,
   output logic [COL_W-1:0]   col,
   output logic               last
);

   logic [GLYPH_W-1:0] shift_q;
   logic [COL_W-1:0]   col_q;

   // The leftmost pixel leaves on the load cycle itself, so only the
   // remaining pixels are kept, already lined up at the MSB.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shift_q <= '0;
         col_q   <= '0;
      end else if (load) begin
         shift_q <= {data_in[GLYPH_W-2:0], 1'b0};
         col_q   <= '0;
      end else if (shift) begin
         shift_q <= {shift_q[GLYPH_W-2:0], 1'b0};
         col_q   <= col_q + COL_W'(1);
      end
   end

   assign next_bit = load ? data_in[GLYPH_W-1] : shift_q[GLYPH_W-1];
   assign col      = col_q;
   assign last     = (col_q == COL_W'(GLYPH_W - 1));

endmodule

// File: rtl/letter_show_writer.sv
// Port-A write controller for the 256x256 letter-show bitmap: draws 8x16
// glyph cells fetched from a synchronous font ROM, or clears the whole bitmap.
module letter_show_writer
   import letter_show_pkg::*;
#(
   parameter logic       CLEAR_VAL  = 1'b0,
   parameter logic [6:0] BLANK_CODE = 7'h20,
   parameter int         FONT_LAT   = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 char_valid,
   output logic                 char_ready,
   input  logic [6:0]           char_code,
   input  logic [CX_W-1:0]      char_cx,
   input  logic [CY_W-1:0]      char_cy,
   input  logic                 clear_req,
   output logic                 busy,
   output logic                 done,
   output logic [6+ROW_W:0]     font_addr,
   input  logic [GLYPH_W-1:0]   font_data,
   output logic                 ram_cea,
   output logic [ADDR_W-1:0]    ram_ada,
   output logic                 ram_din
);

   // The FETCH/WAIT pair below assumes the ROM answers one cycle after the address.
   if (FONT_LAT != 1) begin : g_font_lat_check
      $error("letter_show_writer: only FONT_LAT=1 is supported");
   end

   state_t                 state_q, state_d;
   logic [6:0]             code_q, code_d;
   logic [CX_W-1:0]        cx_q, cx_d;
   logic [CY_W-1:0]        cy_q, cy_d;
   logic [ROW_W-1:0]       row_q, row_d;
   logic [6+ROW_W:0]       font_addr_q, font_addr_d;
   logic [ADDR_W-1:0]      ada_q, ada_d;
   logic                   cea_q, cea_d;
   logic                   din_q, din_d;
   logic                   done_q, done_d;
   logic                   busy_q, busy_d;
   logic                   idle_q, idle_d;

   logic                   ser_load, ser_shift, ser_bit, ser_last;
   logic [COL_W-1:0]       ser_col, col_inc;

   letter_row_serializer u_serializer (
      .clk      (clk),
      .reset    (reset),
      .load     (ser_load),
      .shift    (ser_shift),
      .data_in  (font_data),
      .next_bit (ser_bit),
      .col      (ser_col),
      .last     (ser_last)
   );

   // idle_q is a flop, so ready only needs clear_req gated in to keep the
   // clear-over-draw priority visible in the same cycle.
   assign char_ready = idle_q & ~clear_req;
   assign col_inc    = ser_col + COL_W'(1);

   // Next-state and next-output logic; every output flop is loaded from here
   // so the port values line up with the state they belong to.
   always_comb begin
      state_d     = state_q;
      code_d      = code_q;
      cx_d        = cx_q;
      cy_d        = cy_q;
      row_d       = row_q;
      font_addr_d = font_addr_q;
      ada_d       = ada_q;
      din_d       = din_q;
      cea_d       = 1'b0;
      ser_load    = 1'b0;
      ser_shift   = 1'b0;

      case (state_q)
         IDLE: begin
            if (idle_q && clear_req) begin
               state_d = CLEAR;
               cea_d   = 1'b1;
               ada_d   = '0;
               din_d   = CLEAR_VAL;
            end else if (char_valid && char_ready) begin
               state_d     = FETCH;
               code_d      = printable_code(char_code, BLANK_CODE);
               cx_d        = char_cx;
               cy_d        = char_cy;
               row_d       = '0;
               font_addr_d = {printable_code(char_code, BLANK_CODE), {ROW_W{1'b0}}};
            end
         end

         FETCH: begin
            state_d = WAIT;
         end

         WAIT: begin
            state_d  = WRITE;
            ser_load = 1'b1;
            cea_d    = 1'b1;
            ada_d    = {cy_q, row_q, cx_q, {COL_W{1'b0}}};
            din_d    = ser_bit;
         end

         WRITE: begin
            if (!ser_last) begin
               ser_shift = 1'b1;
               cea_d     = 1'b1;
               ada_d     = {cy_q, row_q, cx_q, col_inc};
               din_d     = ser_bit;
            end else if (row_q == ROW_W'(GLYPH_H - 1)) begin
               state_d = FIN;
            end else begin
               state_d     = FETCH;
               row_d       = row_q + ROW_W'(1);
               font_addr_d = {code_q, row_q + ROW_W'(1)};
            end
         end

         CLEAR: begin
            // The sweep stops on the all-ones address rather than wrapping to 0.
            if (ada_q == {ADDR_W{1'b1}}) begin
               state_d = FIN;
            end else begin
               cea_d = 1'b1;
               ada_d = ada_q + ADDR_W'(1);
               din_d = CLEAR_VAL;
            end
         end

         FIN: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      done_d = (state_d == FIN);
      busy_d = (state_d != IDLE);
      idle_d = (state_d == IDLE);
   end

   // State, captured request and registered outputs; reset abandons any
   // operation in flight and drops every output low.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         code_q      <= '0;
         cx_q        <= '0;
         cy_q        <= '0;
         row_q       <= '0;
         font_addr_q <= '0;
         ada_q       <= '0;
         cea_q       <= 1'b0;
         din_q       <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         idle_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         code_q      <= code_d;
         cx_q        <= cx_d;
         cy_q        <= cy_d;
         row_q       <= row_d;
         font_addr_q <= font_addr_d;
         ada_q       <= ada_d;
         cea_q       <= cea_d;
         din_q       <= din_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
         idle_q      <= idle_d;
      end
   end

   assign font_addr = font_addr_q;
   assign ram_cea   = cea_q;
   assign ram_ada   = ada_q;
   assign ram_din   = din_q;
   assign done      = done_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_letter_show_writer.sv
// Randomised bench for letter_show_writer: a cycle-timeline model of draws
// and clears is compared against every port on every falling edge.
module tb_letter_show_writer;

   localparam int   DRAW_CYC  = 161;
   localparam int   CLR_CYC   = 65537;
   localparam logic CLEAR_VAL = 1'b0;

   typedef enum int {OP_RST, OP_NONE, OP_DRAW, OP_CLR} op_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        char_valid = 1'b0;
   logic        clear_req = 1'b0;
   logic [6:0]  char_code = '0;
   logic [4:0]  char_cx = '0;
   logic [3:0]  char_cy = '0;
   logic [7:0]  font_data = '0;
   logic        char_ready, busy, done, ram_cea, ram_din;
   logic [10:0] font_addr;
   logic [15:0] ram_ada;

   int n_cmp = 0;
   int n_fail = 0;

   op_t         m_op = OP_RST;
   int          m_n = 0;
   int          m_cx = 0;
   int          m_cy = 0;
   int          m_wr = 0;
   logic [6:0]  m_code = '0;
   logic [6:0]  m_raw = '0;
   logic [15:0] m_ada = '0;
   logic        m_din = 1'b0;
   logic [10:0] m_font = '0;

   always #5 clk = ~clk;

   letter_show_writer #(
      .CLEAR_VAL  (CLEAR_VAL),
      .BLANK_CODE (7'h20),
      .FONT_LAT   (1)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .char_valid (char_valid),
      .char_ready (char_ready),
      .char_code  (char_code),
      .char_cx    (char_cx),
      .char_cy    (char_cy),
      .clear_req  (clear_req),
      .busy       (busy),
      .done       (done),
      .font_addr  (font_addr),
      .font_data  (font_data),
      .ram_cea    (ram_cea),
      .ram_ada    (ram_ada),
      .ram_din    (ram_din)
   );

   // Font ROM stand-in: 'A' is a fixed 8'h18 bar, everything else is a hash.
   function automatic logic [7:0] glyph(input logic [6:0] c, input logic [3:0] r);
      logic [7:0] t;
      if (c == 7'h41) return 8'h18;
      t = ({1'b0, c} * 8'd37) ^ ({4'b0, r} * 8'd91) ^ 8'hC3;
      return t;
   endfunction

   always @(posedge clk) font_data <= glyph(font_addr[10:4], font_addr[3:0]);

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Model: which operation is running and how many cycles into it we are.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_op = OP_RST; m_n = 0; m_ada = '0; m_din = 1'b0; m_font = '0;
      end else if (m_op == OP_RST) begin
         m_op = OP_NONE;
      end else if (m_op == OP_DRAW || m_op == OP_CLR) begin
         if (m_n == ((m_op == OP_DRAW) ? DRAW_CYC : CLR_CYC)) begin
            m_op = OP_NONE; m_n = 0;
         end else begin
            m_n++;
         end
      end else if (clear_req) begin
         m_op = OP_CLR; m_n = 1; m_wr = 0;
      end else if (char_valid) begin
         m_op = OP_DRAW; m_n = 1; m_wr = 0; m_raw = char_code;
         m_code = (char_code < 7'h20 || char_code > 7'h7E) ? 7'h20 : char_code;
         m_cx = int'(char_cx); m_cy = int'(char_cy);
      end
   end

   // Compare: cycle n of a draw is row (n-1)/10, phase (n-1)%10 where phases
   // 2..9 write columns 0..7; cycle n of a clear writes address n-1.
   always @(negedge clk) begin
      logic       exp_cea, exp_done;
      int         r, p;
      logic [7:0] g;
      if (!reset && m_op != OP_RST) begin
         exp_cea = 1'b0; exp_done = 1'b0;
         if (m_op == OP_DRAW) begin
            if (m_n == DRAW_CYC) exp_done = 1'b1;
            else begin
               r = (m_n - 1) / 10; p = (m_n - 1) % 10;
               if (p == 0) m_font = {m_code, 4'(r)};
               if (p >= 2) begin
                  exp_cea = 1'b1;
                  m_ada = 16'(((m_cy * 16 + r) << 8) + m_cx * 8 + (p - 2));
                  g = glyph(m_code, 4'(r));
                  m_din = g[9 - p];
               end
            end
         end else if (m_op == OP_CLR) begin
            if (m_n == CLR_CYC) exp_done = 1'b1;
            else begin
               exp_cea = 1'b1; m_ada = 16'(m_n - 1); m_din = CLEAR_VAL;
            end
         end
         if (ram_cea === 1'b1) m_wr++;
         check_output("ram_cea", ram_cea, exp_cea);
         check_output("ram_ada", ram_ada, m_ada);
         check_output("ram_din", ram_din, m_din);
         check_output("font_addr", font_addr, m_font);
         check_output("busy", busy, m_op != OP_NONE);
         check_output("done", done, exp_done);
         check_output("char_ready", char_ready, (m_op == OP_NONE) && !clear_req);
         if (exp_done) check_output("write_count", m_wr, (m_op == OP_DRAW) ? 128 : 65536);
         if (m_op == OP_DRAW && m_code == 7'h41 && m_cx == 0 && m_cy == 0) begin
            if (m_n == 3) begin
               check_output("a_first_ada", ram_ada, 16'h0000);
               check_output("a_first_din", ram_din, 1'b0);
               check_output("a_first_cea", ram_cea, 1'b1);
            end
            if (m_n == 6) begin
               check_output("a_col3_ada", ram_ada, 16'h0003);
               check_output("a_col3_din", ram_din, 1'b1);
            end
            if (m_n == 160) check_output("a_last_ada", ram_ada, 16'h0F07);
            if (m_n == 161) check_output("a_done_161", done, 1'b1);
         end
         if (m_op == OP_DRAW && m_cx == 31 && m_cy == 15 && m_n == 160)
            check_output("corner_last_ada", ram_ada, 16'hFFFF);
         if (m_op == OP_DRAW && m_raw == 7'h07 && m_n < DRAW_CYC && (m_n - 1) % 10 == 0)
            check_output("blank_code", font_addr[10:4], 7'h20);
      end
   end

   task automatic wait_model(input op_t op, input int min_n, input int budget, input string name);
      int k = 0;
      while (!(m_op == op && m_n >= min_n) && k < budget) begin
         @(negedge clk); k++;
      end
      if (!(m_op == op && m_n >= min_n)) begin
         n_cmp++; n_fail++;
         $display("[TB] FAIL timeout_%s: waited %0d cycles, required op %0d", name, k, op);
      end
   endtask

   task automatic apply_stimulus(input logic [6:0] code, input logic [4:0] cx,
                                 input logic [3:0] cy, input bit pulse_clear);
      @(negedge clk); #2;
      char_valid = 1'b1; char_code = code; char_cx = cx; char_cy = cy;
      @(negedge clk);
      wait_model(OP_DRAW, 1, 70000, "accept");
      #2 char_valid = 1'b0;
      if (pulse_clear) begin
         repeat (40) @(negedge clk);
         #2 clear_req = 1'b1;
         @(negedge clk); #2 clear_req = 1'b0;
      end
      wait_model(OP_NONE, 0, 400, "draw_end");
   endtask

   initial begin
      $display("[TB] letter_show_writer bench start");
      repeat (3) @(negedge clk);
      #2 reset = 1'b0;
      @(posedge clk); @(negedge clk);
      check_output("ready_after_init", char_ready, 1'b1);

      apply_stimulus(7'h41, 5'd0, 4'd0, 1'b0);
      apply_stimulus(7'h4D, 5'd31, 4'd15, 1'b0);
      apply_stimulus(7'h07, 5'd9, 4'd4, 1'b0);

      // Clear and draw offered together: clear wins, draw waits it out.
      @(negedge clk); #2;
      clear_req = 1'b1; char_valid = 1'b1; char_code = 7'h5A; char_cx = 5'd7; char_cy = 4'd3;
      #1 check_output("ready_vs_clear", char_ready, 1'b0);
      @(negedge clk); #2 clear_req = 1'b0;
      wait_model(OP_DRAW, 1, 70000, "draw_after_clear");
      #2 char_valid = 1'b0;
      wait_model(OP_NONE, 0, 400, "draw_after_clear_end");

      apply_stimulus(7'h62, 5'd12, 4'd8, 1'b1);

      for (int i = 0; i < 10; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         apply_stimulus(7'($urandom_range(0, 127)), 5'($urandom_range(0, 31)),
                        4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      end

      // Reset in the middle of a clear sweep.
      @(negedge clk); #2 clear_req = 1'b1;
      @(negedge clk); #2 clear_req = 1'b0;
      wait_model(OP_CLR, 1000, 2000, "clear_1000");
      #1 reset = 1'b1;
      #1;
      check_output("rst_cea", ram_cea, 1'b0);
      check_output("rst_ada", ram_ada, 16'h0000);
      check_output("rst_din", ram_din, 1'b0);
      check_output("rst_font", font_addr, 11'h000);
      check_output("rst_done", done, 1'b0);
      check_output("rst_busy", busy, 1'b0);
      check_output("rst_ready", char_ready, 1'b0);
      repeat (2) @(negedge clk);
      #2 reset = 1'b0;
      @(posedge clk); @(negedge clk);
      check_output("ready_after_reset", char_ready, 1'b1);

      apply_stimulus(7'h33, 5'd20, 4'd2, 1'b0);
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
